// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port, r0 fixed at zero.
// Optional same-cycle write-through on busA/busB when REGFILE_BYPASS_EN is defined.
module regfile #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWr,
    input  logic [DEPTH_LOG2-1:0] Rw,
    input  logic [WIDTH-1:0]      busW,
    input  logic [DEPTH_LOG2-1:0] Ra,
    input  logic [DEPTH_LOG2-1:0] Rb,
    output logic [WIDTH-1:0]      busA,
    output logic [WIDTH-1:0]      busB,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] stored [DEPTH];

    // Flop-based storage: every register must clear on reset and all reads are asynchronous.
    // Entry 0 has no storage at all, which makes the zero register true by construction.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign stored[gi] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] q_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else if (RegWr && (Rw == DEPTH_LOG2'(gi))) begin
                        q_reg <= busW;
                    end
                end
                assign stored[gi] = q_reg;
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic wr_active;
    assign wr_active = RegWr && !rst && (Rw != '0);
    assign busA = (wr_active && (Ra == Rw)) ? busW : stored[Ra];
    assign busB = (wr_active && (Rb == Rw)) ? busW : stored[Rb];
`else
    assign busA = stored[Ra];
    assign busB = stored[Rb];
`endif

    // Debug port always shows committed state, never the write-through value.
    assign dbg_data = stored[dbg_addr];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed test-plan sequences plus random traffic,
// with an array reference model, an expectation queue and a decoupled monitor.
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .RegWr    (RegWr),
        .Rw       (Rw),
        .busW     (busW),
        .Ra       (Ra),
        .Rb       (Rb),
        .busA     (busA),
        .busB     (busB),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  da;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
    } exp_t;

    exp_t        expq[$];
    event        sample_ev;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];

    function automatic logic [31:0] ref_read(input logic [4:0] addr, input bit use_bypass);
        if (addr == 5'd0) return 32'd0;
        if (use_bypass && BYP && RegWr && !rst && (Rw != 5'd0) && (addr == Rw)) return busW;
        return model[addr];
    endfunction

    // One cycle: apply inputs after the falling edge, post the expected outputs, then
    // advance the model across the rising edge.
    task automatic step(input string name, input logic r, input logic we, input logic [4:0] rw,
                        input logic [31:0] w, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] da);
        exp_t e;
        @(negedge clk);
        rst = r; RegWr = we; Rw = rw; busW = w; Ra = ra; Rb = rb; dbg_addr = da;
        #1;
        e.name = name; e.ra = ra; e.rb = rb; e.da = da;
        e.a = ref_read(ra, 1'b1);
        e.b = ref_read(rb, 1'b1);
        e.d = ref_read(da, 1'b0);
        expq.push_back(e);
        -> sample_ev;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && rw != 5'd0) begin
            model[rw] = w;
        end
    endtask

    task automatic rd(input string name, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
        step(name, 1'b0, 1'b0, 5'd0, $urandom, ra, rb, da);
    endtask

    task automatic wr(input string name, input logic [4:0] rw, input logic [31:0] w);
        step(name, 1'b0, 1'b1, rw, w, rw, 5'(rw + 5'd1), rw);
    endtask

    // Monitor: consumes one expectation per presented sample.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (expq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL queue_underflow: sample with no expectation");
            end else begin
                e = expq.pop_front();
                checks += 3;
                if (busA !== e.a) begin
                    errors++;
                    $display("FAIL %s busA Ra=%0d got=%h exp=%h", e.name, e.ra, busA, e.a);
                end
                if (busB !== e.b) begin
                    errors++;
                    $display("FAIL %s busB Rb=%0d got=%h exp=%h", e.name, e.rb, busB, e.b);
                end
                if (dbg_data !== e.d) begin
                    errors++;
                    $display("FAIL %s dbg addr=%0d got=%h exp=%h", e.name, e.da, dbg_data, e.d);
                end
                $display("txn %s rst=%0b we=%0b Rw=%0d busW=%h | A[%0d]=%h B[%0d]=%h D[%0d]=%h",
                         e.name, rst, RegWr, Rw, busW, e.ra, busA, e.rb, busB, e.da, dbg_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ra, rb, rw;
        rst = 1'b1; RegWr = 1'b0; Rw = '0; busW = '0; Ra = '0; Rb = '0; dbg_addr = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        repeat (2) @(posedge clk);

        // Reset clear, including all 32 debug reads
        rd("post_reset", 5'd5, 5'd31, 5'd0);
        wr("wr_r5", 5'd5, 32'hDEADBEEF);
        rd("rd_r5", 5'd5, 5'd5, 5'd5);
        step("rst_r5", 1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
        for (int i = 0; i < 32; i++) rd("rst_sweep", 5'(i), 5'(31 - i), 5'(i));

        // Write / read, then RegWr=0 leaves r7 alone
        wr("wr_r7", 5'd7, 32'h12345678);
        rd("rd_r7", 5'd7, 5'd7, 5'd7);
        step("nowr_r7", 1'b0, 1'b0, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd7, 5'd7);
        rd("rd_r7_keep", 5'd7, 5'd7, 5'd7);

        // r0 hard-wired
        step("wr_r0", 1'b0, 1'b1, 5'd0, 32'hAAAAAAAA, 5'd0, 5'd0, 5'd0);
        rd("rd_r0", 5'd0, 5'd0, 5'd0);

        // Reset wins over a same-edge write
        wr("wr_r3", 5'd3, 32'h00000077);
        step("rst_vs_wr", 1'b1, 1'b1, 5'd3, 32'h00000055, 5'd3, 5'd3, 5'd3);
        rd("rd_r3", 5'd3, 5'd3, 5'd3);

        // Same-cycle read of the write target
        wr("wr_r9", 5'd9, 32'h1);
        step("rw_same", 1'b0, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9);
        rd("rd_r9", 5'd9, 5'd9, 5'd9);

        // Back-to-back writes to one register
        wr("b2b_1", 5'd10, 32'hCAFE0001);
        wr("b2b_2", 5'd10, 32'hCAFE0002);
        rd("rd_r10", 5'd10, 5'd10, 5'd10);

        // Full sweep
        for (int i = 1; i < 32; i++) wr("sweep_wr", 5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) rd("sweep_rd", 5'(i), 5'(31 - i), 5'(i));

        // Random traffic, with read addresses biased toward the write target
        for (int n = 0; n < 200; n++) begin
            rw = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            step("rand", ($urandom_range(0, 24) == 0), 1'($urandom), rw, $urandom, ra, rb,
                 ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, required 0", expq.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
